// File: rtl/o_sync_lock_ctrl.sv
// Scope capture-path sequencer: qualifies HS/VS timing on O_CLK and
// enables the scope pixel/line counter on a frame boundary once locked.
module o_sync_lock_ctrl #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_TOTAL     = 417,
    parameter int unsigned H_TOL       = 4,
    parameter int unsigned V_TOL       = 2,
    parameter int unsigned LOCK_FRAMES = 4,
    parameter logic [19:0] TIMEOUT     = 20'hFFFFF,
    parameter logic        HS_POL      = 1'b0,
    parameter logic        VS_POL      = 1'b0
) (
    input  logic       O_CLK,
    input  logic       RESET,
    input  logic       O_HS,
    input  logic       O_VS,
    input  logic       REQ_EN,
    output logic       ENABLE,
    output logic       LOCKED,
    output logic [1:0] STATE,
    output logic [9:0] LINE_PERIOD,
    output logic [8:0] FRAME_LINES,
    output logic       ERR_PULSE
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;

    localparam logic [10:0] H_HI   = 11'(H_TOTAL + H_TOL);
    localparam logic [10:0] H_LO   = 11'(H_TOTAL - H_TOL);
    localparam logic [9:0]  V_HI   = 10'(V_TOTAL + V_TOL);
    localparam logic [9:0]  V_LO   = 10'(V_TOTAL - V_TOL);
    localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

    logic        r_hs_q, r_hs_p, r_vs_q, r_vs_p;
    logic [1:0]  r_state;
    logic [9:0]  r_pcnt;
    logic [8:0]  r_lcnt;
    logic [19:0] r_wd;
    logic [2:0]  r_good;
    logic        r_badline, r_first;
    logic        r_enable, r_locked, r_err;
    logic [9:0]  r_line_period;
    logic [8:0]  r_frame_lines;

    logic        w_hs_edge, w_vs_edge;
    logic        w_line_bad, w_lines_ok, w_frame_good;
    logic        w_timeout, w_clear;
    logic [2:0]  w_good_inc;
    logic [1:0]  w_state_nxt;
    logic [2:0]  w_good_nxt;
    logic        w_first_nxt, w_err_nxt;

    assign w_hs_edge = (r_hs_q == HS_POL) && (r_hs_p != HS_POL);
    assign w_vs_edge = (r_vs_q == VS_POL) && (r_vs_p != VS_POL);

    // Saturated counts are forced bad regardless of the nominal window.
    assign w_line_bad = (r_pcnt == 10'd1023)
                     || ({1'b0, r_pcnt} > H_HI)
                     || ({1'b0, r_pcnt} < H_LO);
    assign w_lines_ok = (r_lcnt != 9'd511)
                     && ({1'b0, r_lcnt} <= V_HI)
                     && ({1'b0, r_lcnt} >= V_LO);

    // A line ending on the VS edge itself still belongs to the old frame.
    assign w_frame_good = w_lines_ok && !r_badline
                       && !(w_hs_edge && w_line_bad);

    assign w_timeout  = !w_hs_edge && (r_wd == TIMEOUT);
    assign w_clear    = (r_state == S_IDLE) || !REQ_EN;
    assign w_good_inc = (r_good == 3'd7) ? 3'd7 : r_good + 3'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_first_nxt = r_first;
        w_err_nxt   = 1'b0;
        if (w_clear) begin
            w_state_nxt = REQ_EN ? S_SEARCH : S_IDLE;
            w_good_nxt  = 3'd0;
            w_first_nxt = REQ_EN;
        end else if (w_timeout) begin
            w_state_nxt = S_SEARCH;
            w_good_nxt  = 3'd0;
            w_first_nxt = 1'b1;
            w_err_nxt   = 1'b1;
        end else if (w_vs_edge) begin
            if (r_first) begin
                w_first_nxt = 1'b0;
            end else if (w_frame_good) begin
                w_good_nxt = w_good_inc;
                if (r_state == S_SEARCH && {1'b0, w_good_inc} >= LOCK_N)
                    w_state_nxt = S_RUN;
            end else begin
                w_state_nxt = S_SEARCH;
                w_good_nxt  = 3'd0;
                w_first_nxt = 1'b0;
                w_err_nxt   = 1'b1;
            end
        end
    end

    always_ff @(posedge O_CLK) begin
        if (RESET) begin
            r_hs_q <= HS_POL;
            r_hs_p <= HS_POL;
            r_vs_q <= VS_POL;
            r_vs_p <= VS_POL;
        end else begin
            r_hs_q <= O_HS;
            r_hs_p <= r_hs_q;
            r_vs_q <= O_VS;
            r_vs_p <= r_vs_q;
        end
    end

    always_ff @(posedge O_CLK) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_good   <= 3'd0;
            r_first  <= 1'b0;
            r_enable <= 1'b0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_good   <= w_good_nxt;
            r_first  <= w_first_nxt;
            r_enable <= (w_state_nxt == S_RUN);
            r_locked <= (w_state_nxt == S_RUN);
            r_err    <= w_err_nxt;
        end
    end

    always_ff @(posedge O_CLK) begin
        if (RESET) begin
            r_pcnt        <= 10'd0;
            r_lcnt        <= 9'd0;
            r_wd          <= 20'd0;
            r_badline     <= 1'b0;
            r_line_period <= 10'd0;
            r_frame_lines <= 9'd0;
        end else if (w_clear) begin
            r_pcnt    <= 10'd0;
            r_lcnt    <= 9'd0;
            r_wd      <= 20'd0;
            r_badline <= 1'b0;
        end else begin
            if (w_hs_edge) begin
                r_pcnt        <= 10'd1;
                r_wd          <= 20'd1;
                r_line_period <= r_pcnt;
            end else begin
                if (r_pcnt != 10'd1023)
                    r_pcnt <= r_pcnt + 10'd1;
                r_wd <= w_timeout ? 20'd0 : r_wd + 20'd1;
            end
            if (w_vs_edge) begin
                r_frame_lines <= r_lcnt;
                r_lcnt        <= {8'd0, w_hs_edge};
                r_badline     <= 1'b0;
            end else if (w_hs_edge) begin
                if (r_lcnt != 9'd511)
                    r_lcnt <= r_lcnt + 9'd1;
                if (w_line_bad)
                    r_badline <= 1'b1;
            end
        end
    end

    assign ENABLE      = r_enable;
    assign LOCKED      = r_locked;
    assign STATE       = r_state;
    assign LINE_PERIOD = r_line_period;
    assign FRAME_LINES = r_frame_lines;
    assign ERR_PULSE   = r_err;

endmodule
